switch_route_sequencer: RTL and testbench
=========================================

Name: switch_route_sequencer

Overview:
- Control-layer sequencer that drives the valve commands of the two 9-switch flow-switch chains and the 3-port merge switch feeding the Filter/Mixer/Heater/Filter output path.
- Accepts one route request at a time: a chain plus a target leaf, or a target of "through to the output merge".
- Opens the route, waits for valve actuation to settle, holds flow for a requested dwell, then closes every valve and waits for actuation again before accepting the next request.

Parameters:
- N_SW, 9, switches per chain; the chain has 2*N_SW leaves.
- ACT_CYCLES, 4, valve actuation settle time in clocks (minimum 1).
- DW, 16, width of the dwell counter.
- TW, $clog2(2*N_SW+1), target index width; derived, not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  1  route request valid.
- req_ready  out  1  high only in IDLE.
- req_chain  in  1  chain select: 0 = Source1 chain, 1 = Source2 chain.
- req_target  in  TW  0..2*N_SW-1 selects a leaf; 2*N_SW routes through the whole chain into the merge switch.
- req_dwell  in  DW  flow hold time in clocks; 0 is legal.
- abort  in  1  cuts SETTLE/FLOW short.
- sw_cmd  out  4*N_SW  2-bit command per switch. Chain c, switch i occupies bits [2*(c*N_SW+i)+1 : 2*(c*N_SW+i)]. Encoding: 00 closed, 01 pass-through, 10 leaf A (even target), 11 leaf B (odd target).
- merge_cmd  out  2  00 closed, 01 chain0→out, 10 chain1→out.
- busy  out  1  high whenever not in IDLE.
- done  out  1  one-cycle pulse on return to IDLE.
- aborted  out  1  valid with done; 1 if the run was aborted.
- err  out  1  one-cycle pulse for a rejected request.

Behaviour:
- Reset (async, rst_n=0): all outputs 0 immediately, including sw_cmd, merge_cmd, done and err; state returns to IDLE. On release, req_ready=1 from the first clock. Reset mid-route closes all valves at once, with no CLOSE wait.
- Handshake: request accepted on a rising edge with req_valid && req_ready. Inputs are sampled only at that edge.
- Invalid target (req_target > 2*N_SW): the request is accepted, then:
  - err pulses in the following cycle;
  - state stays IDLE and no valve changes;
  - req_ready stays 1.
- Path decode, for a valid target t on chain c:
  - t < 2*N_SW, k = t/2: switches 0..k-1 get 01, switch k gets 10 if t is even and 11 if t is odd, all others 00. merge_cmd = 00.
  - t = 2*N_SW: all N_SW switches of chain c get 01, merge_cmd = c+1.
  - The other chain is always all 00.
- States:
  - IDLE: req_ready=1. A valid accept goes to SETTLE; decoded commands appear on sw_cmd/merge_cmd in the cycle after the accept edge, registered.
  - SETTLE: commands held for exactly ACT_CYCLES cycles. Then FLOW if dwell>0, else CLOSE.
  - FLOW: commands held for exactly req_dwell cycles, then CLOSE.
  - CLOSE: sw_cmd=0 and merge_cmd=0 for ACT_CYCLES cycles, then IDLE. done pulses in the first IDLE cycle.
- abort:
  - In SETTLE or FLOW, the next cycle is CLOSE and aborted=1 with the eventual done.
  - Ignored in IDLE and CLOSE.
  - abort coinciding with the final SETTLE/FLOW cycle still marks aborted and enters CLOSE.
- Busy duration for a non-aborted run: ACT_CYCLES + dwell + ACT_CYCLES cycles.
- A request presented in the same cycle as done is accepted, since req_ready=1 in IDLE. That gives back-to-back routes with a one-cycle IDLE gap.
- Counters use DW bits and never wrap. The maximum dwell is 2^DW-1.
- sw_cmd only changes on IDLE→SETTLE, on entry to CLOSE, or on reset. No intermediate combinational glitch values are visible.

Decomposition:
- Shared package (flow_ctrl_pkg):
  - sw_cmd_t enum: CLOSED, PASS, LEAF_A, LEAF_B;
  - merge_cmd_t enum;
  - route state enum;
  - N_SW default constant.
- One sub-module, switch_path_decode: combinational (chain, target) → (sw_cmd, merge_cmd, invalid). Registered by the parent.

Test Plan:
- Reset mid-FLOW, then release → sw_cmd=0, busy=0, req_ready=1 with no done pulse.
- chain=0, target=5, dwell=10 → after accept, sw_cmd[5:0]=6'b11_01_01 and all other bits 0. The route holds 14 cycles, sw_cmd is 0 for 4 cycles, done pulses with aborted=0, and busy lasts 18 cycles.
- chain=1, target=18, dwell=0 → chain1 switches all 01, merge_cmd=10 for 4 cycles, close for 4 cycles, then done. Chain0 bits stay 0 throughout.
- chain=0, target=0, dwell=100, abort asserted 3 cycles into FLOW → CLOSE the next cycle, then done with aborted=1 exactly 4 cycles later.
- target=19 → err pulse one cycle after accept, sw_cmd unchanged, busy never rises.
- Back-to-back: a second request held valid while done pulses → accepted that cycle, with new commands on the following cycle.

Source files
------------

// File: rtl/flow_ctrl_pkg.sv
// Shared types for the flow-switch route sequencer.
// Valve command encodings, merge commands and route states.
package flow_ctrl_pkg;

  localparam int N_SW_DEF = 9;

  typedef enum logic [1:0] {
    CLOSED = 2'b00,
    PASS   = 2'b01,
    LEAF_A = 2'b10,
    LEAF_B = 2'b11
  } sw_cmd_t;

  typedef enum logic [1:0] {
    M_CLOSED = 2'b00,
    M_CHAIN0 = 2'b01,
    M_CHAIN1 = 2'b10
  } merge_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_FLOW   = 2'd2,
    ST_CLOSE  = 2'd3
  } route_state_t;

endpackage

// File: rtl/switch_path_decode.sv
// Combinational (chain, target) to valve command decode.
// Target 2*N_SW routes through every switch into the merge.
module switch_path_decode
  import flow_ctrl_pkg::*;
#(
  parameter  int N_SW = N_SW_DEF,
  localparam int TW   = $clog2(2*N_SW+1)
) (
  input  logic              chain,
  input  logic [TW-1:0]     target,
  output logic [4*N_SW-1:0] sw_cmd,
  output logic [1:0]        merge_cmd,
  output logic              invalid
);

  localparam logic [TW-1:0] THRU = TW'(2*N_SW);

  logic [TW-2:0] k;
  sw_cmd_t       leaf;

  assign k    = target[TW-1:1];
  assign leaf = target[0] ? LEAF_B : LEAF_A;

  always_comb begin
    sw_cmd    = '0;
    merge_cmd = M_CLOSED;
    invalid   = target > THRU;
    if (!invalid) begin
      // k == N_SW for the through route, so no leaf is selected
      for (int i = 0; i < N_SW; i++) begin
        if (i < int'(k))
          sw_cmd[2*(int'(chain)*N_SW+i) +: 2] = PASS;
        else if (i == int'(k))
          sw_cmd[2*(int'(chain)*N_SW+i) +: 2] = leaf;
      end
      if (target == THRU)
        merge_cmd = chain ? M_CHAIN1 : M_CHAIN0;
    end
  end

endmodule

// File: rtl/switch_route_sequencer.sv
// Route sequencer: open, settle, dwell, close, settle.
// Valve commands are registered so they only move on route edges.
module switch_route_sequencer
  import flow_ctrl_pkg::*;
#(
  parameter  int N_SW       = N_SW_DEF,
  parameter  int ACT_CYCLES = 4,
  parameter  int DW         = 16,
  localparam int TW         = $clog2(2*N_SW+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_chain,
  input  logic [TW-1:0]     req_target,
  input  logic [DW-1:0]     req_dwell,
  input  logic              abort,
  output logic [4*N_SW-1:0] sw_cmd,
  output logic [1:0]        merge_cmd,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              err
);

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] SETTLE = ST_SETTLE;
  localparam logic [1:0] FLOW   = ST_FLOW;
  localparam logic [1:0] CLOSE  = ST_CLOSE;

  localparam logic [DW-1:0] ACT_M1 = DW'(ACT_CYCLES-1);

  logic [1:0]        state;
  logic [DW-1:0]     cnt;
  logic [DW-1:0]     dwell;
  logic              ab;
  logic [4*N_SW-1:0] dec_sw;
  logic [1:0]        dec_merge;
  logic              dec_inv;
  logic              accept;
  logic              cut;
  logic              last;
  logic              go_close;

  switch_path_decode #(.N_SW(N_SW)) u_decode (
    .chain     (req_chain),
    .target    (req_target),
    .sw_cmd    (dec_sw),
    .merge_cmd (dec_merge),
    .invalid   (dec_inv)
  );

  assign req_ready = rst_n && (state == IDLE);
  assign busy      = state != IDLE;
  assign accept    = req_valid && req_ready;
  assign cut       = abort && (state == SETTLE || state == FLOW);
  assign last      = cnt == '0;
  assign go_close  = cut
                  || (state == SETTLE && last && dwell == '0)
                  || (state == FLOW && last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      dwell     <= '0;
      ab        <= 1'b0;
      sw_cmd    <= '0;
      merge_cmd <= '0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      err       <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      err     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept && dec_inv) begin
            err <= 1'b1;
          end else if (accept) begin
            state     <= SETTLE;
            cnt       <= ACT_M1;
            dwell     <= req_dwell;
            ab        <= 1'b0;
            sw_cmd    <= dec_sw;
            merge_cmd <= dec_merge;
          end
        end
        SETTLE, FLOW: begin
          if (go_close) begin
            state     <= CLOSE;
            cnt       <= ACT_M1;
            sw_cmd    <= '0;
            merge_cmd <= '0;
            if (cut) ab <= 1'b1;
          end else if (last) begin
            state <= FLOW;
            cnt   <= dwell - DW'(1);
          end else begin
            cnt <= cnt - DW'(1);
          end
        end
        CLOSE: begin
          if (last) begin
            state   <= IDLE;
            done    <= 1'b1;
            aborted <= ab;
          end else begin
            cnt <= cnt - DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_route_sequencer.sv
// Bench for switch_route_sequencer: timeline model plus
// hand-computed literal expectations.
module tb_switch_route_sequencer;

  localparam int N  = 9;
  localparam int A  = 4;
  localparam int DW = 16;
  localparam int TW = 5;

  localparam int K_SW  = 0;
  localparam int K_MG  = 1;
  localparam int K_BSY = 2;
  localparam int K_RDY = 3;
  localparam int K_DN  = 4;
  localparam int K_AB  = 5;
  localparam int K_ERR = 6;
  localparam int K_TO  = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_chain = 1'b0;
  logic [TW-1:0] req_target = '0;
  logic [DW-1:0] req_dwell = '0;
  logic          abort = 1'b0;
  logic [35:0]   sw_cmd;
  logic [1:0]    merge_cmd;
  logic          busy;
  logic          done;
  logic          aborted;
  logic          err;

  always #5 clk = ~clk;

  switch_route_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_chain  (req_chain),
    .req_target (req_target),
    .req_dwell  (req_dwell),
    .abort      (abort),
    .sw_cmd     (sw_cmd),
    .merge_cmd  (merge_cmd),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .err        (err)
  );

  typedef struct {
    int          cyc;
    int          kind;
    logic [35:0] val;
  } lit_t;

  lit_t lits[$];

  int vectors = 0;
  int miscompares = 0;

  // Model: each route is a set of cycle windows, not a state machine
  int          e = 0;
  int          ms = 0;
  int          mce = -1;
  int          mbe = -1;
  int          mdone = -1;
  int          merr = -1;
  logic        mab = 1'b0;
  logic [35:0] msw = '0;
  logic [1:0]  mmg = '0;

  function automatic logic [35:0] exp_path(input int c, input int t);
    logic [17:0] ch;
    int          k;
    ch = '0;
    k  = t / 2;
    for (int i = 0; i < N; i++)
      if (i < k) ch = ch | (18'(1) << (2*i));
    if (t < 2*N) ch = ch | (18'(2 + t % 2) << (2*k));
    return c != 0 ? {ch, 18'b0} : {18'b0, ch};
  endfunction

  always @(posedge clk) begin
    e <= e + 1;
    if (!rst_n) begin
      ms    <= 0;
      mce   <= -1;
      mbe   <= -1;
      mdone <= -1;
      merr  <= -1;
      mab   <= 1'b0;
    end else if (!(ms <= e && e <= mbe)) begin
      if (req_valid && int'(req_target) > 2*N) begin
        merr <= e + 1;
      end else if (req_valid) begin
        ms    <= e + 1;
        mce   <= e + A + int'(req_dwell);
        mbe   <= e + 2*A + int'(req_dwell);
        mdone <= e + 2*A + int'(req_dwell) + 1;
        mab   <= 1'b0;
        msw   <= exp_path(int'(req_chain), int'(req_target));
        mmg   <= int'(req_target) == 2*N ? 2'(int'(req_chain) + 1) : 2'd0;
      end
    end else if (abort && e <= mce) begin
      mce   <= e;
      mbe   <= e + A;
      mdone <= e + A + 1;
      mab   <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h want %h", name, e, act, req);
    end
  endtask

  function automatic logic [35:0] act_of(input int kind);
    case (kind)
      K_SW:    return sw_cmd;
      K_MG:    return 36'(merge_cmd);
      K_BSY:   return 36'(busy);
      K_RDY:   return 36'(req_ready);
      K_DN:    return 36'(done);
      K_AB:    return 36'(aborted);
      K_ERR:   return 36'(err);
      default: return 36'h1;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs",
          64'({sw_cmd, merge_cmd, busy, req_ready, done, aborted, err}),
          64'(0));
    end else begin
      logic in_b, in_c;
      in_b = ms <= e && e <= mbe;
      in_c = ms <= e && e <= mce;
      chk("sw_cmd", 64'(sw_cmd), 64'(in_c ? msw : 36'h0));
      chk("merge_cmd", 64'(merge_cmd), 64'(in_c ? mmg : 2'd0));
      chk("busy", 64'(busy), 64'(in_b));
      chk("req_ready", 64'(req_ready), 64'(!in_b));
      chk("done", 64'(done), 64'(e == mdone));
      chk("aborted", 64'(aborted), 64'(e == mdone && mab));
      chk("err", 64'(err), 64'(e == merr));
    end
    foreach (lits[i]) begin
      if (lits[i].cyc == e) begin
        if (lits[i].kind == K_TO)
          chk("handshake_timeout", 64'(1), 64'(0));
        else
          chk($sformatf("literal_k%0d", lits[i].kind),
              64'(act_of(lits[i].kind)), 64'(lits[i].val));
      end
    end
  end

  task automatic at(input int cyc, input int kind, input logic [35:0] v);
    lits.push_back('{cyc, kind, v});
  endtask

  task automatic wait_to(input int c);
    while (e < c) @(negedge clk);
  endtask

  task automatic send(input logic c, input int t, input int d,
                      output int s);
    @(negedge clk);
    #1;
    req_valid  = 1'b1;
    req_chain  = c;
    req_target = TW'(t);
    req_dwell  = DW'(d);
    for (int n = 0; n < 200 && !req_ready; n++) begin
      @(negedge clk);
      #1;
    end
    if (!req_ready) at(e + 1, K_TO, '0);
    s = e + 1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  initial begin
    int s, s1, r;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    at(e + 1, K_RDY, 36'h1);
    at(e + 1, K_BSY, 36'h0);

    send(1'b0, 5, 10, s);
    at(s, K_SW, 36'h35);
    at(s + 13, K_SW, 36'h35);
    at(s + 14, K_SW, 36'h0);
    at(s + 17, K_BSY, 36'h1);
    at(s + 18, K_BSY, 36'h0);
    at(s + 18, K_DN, 36'h1);
    at(s + 18, K_AB, 36'h0);
    wait_to(s + 19);

    send(1'b1, 18, 0, s);
    at(s, K_SW, 36'h555540000);
    at(s, K_MG, 36'h2);
    at(s + 3, K_MG, 36'h2);
    at(s + 4, K_SW, 36'h0);
    at(s + 4, K_MG, 36'h0);
    at(s + 8, K_DN, 36'h1);
    wait_to(s + 9);

    send(1'b0, 0, 100, s);
    at(s, K_SW, 36'h2);
    at(s + 6, K_SW, 36'h2);
    at(s + 7, K_SW, 36'h0);
    at(s + 10, K_BSY, 36'h1);
    at(s + 11, K_DN, 36'h1);
    at(s + 11, K_AB, 36'h1);
    wait_to(s + 6);
    #1 abort = 1'b1;
    @(negedge clk);
    #1 abort = 1'b0;
    wait_to(s + 12);

    send(1'b0, 19, 3, s);
    at(s, K_ERR, 36'h1);
    at(s, K_BSY, 36'h0);
    at(s, K_SW, 36'h0);
    at(s + 1, K_ERR, 36'h0);
    wait_to(s + 2);

    // abort spans the last SETTLE cycle and two CLOSE cycles
    send(1'b1, 3, 5, s);
    at(s, K_SW, 36'h340000);
    at(s + 4, K_SW, 36'h0);
    at(s + 8, K_DN, 36'h1);
    at(s + 8, K_AB, 36'h1);
    wait_to(s + 3);
    #1 abort = 1'b1;
    wait_to(s + 6);
    #1 abort = 1'b0;
    wait_to(s + 9);

    send(1'b0, 7, 2, s1);
    at(s1, K_SW, 36'hD5);
    at(s1 + 10, K_DN, 36'h1);
    at(s1 + 10, K_BSY, 36'h0);
    at(s1 + 11, K_BSY, 36'h1);
    at(s1 + 11, K_SW, 36'h15555);
    at(s1 + 11, K_MG, 36'h1);
    wait_to(s1 + 8);
    send(1'b0, 18, 1, s);
    wait_to(s + 10);

    send(1'b0, 2, 50, s);
    at(s, K_SW, 36'h9);
    at(s + 7, K_SW, 36'h9);
    wait_to(s + 8);
    #1 rst_n = 1'b0;
    wait_to(s + 10);
    #1 rst_n = 1'b1;
    r = s + 11;
    at(r, K_BSY, 36'h0);
    at(r, K_RDY, 36'h1);
    at(r, K_SW, 36'h0);
    at(r, K_DN, 36'h0);
    at(r + 1, K_DN, 36'h0);
    wait_to(r + 4);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
